// File: rtl/vote_tally_judge_pkg.sv
// Shared types and width helpers for the vote tally / judge controller.
package vote_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VOTING,
    S_SCAN,
    S_JUDGE,
    S_JSCAN,
    S_DONE
  } vote_state_t;

  // Candidate ID width; a 2-candidate system still needs one ID bit.
  function automatic int cid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int jcnt_w(input int nj);
    return $clog2(nj + 1);
  endfunction

  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/vote_tally_judge_if.sv
// Ballot-entry / judge / result handshake bundle for vote_tally_judge.
interface vote_tally_judge_if
  import vote_pkg::*;
#(
  parameter int CID_W = cid_w(4)
);
  logic             start;
  logic             vote_valid;
  logic [CID_W-1:0] vote_cand;
  logic             vote_ready;
  logic             close;
  logic             judge_valid;
  logic [CID_W-1:0] judge_cand;
  logic             judge_ready;
  logic             result_valid;
  logic [CID_W-1:0] winner;
  logic             judged;
  logic             unresolved;
  logic             overflow;

  modport master (
    output start, vote_valid, vote_cand, close, judge_valid, judge_cand,
    input  vote_ready, judge_ready, result_valid, winner, judged, unresolved, overflow
  );

  modport slave (
    input  start, vote_valid, vote_cand, close, judge_valid, judge_cand,
    output vote_ready, judge_ready, result_valid, winner, judged, unresolved, overflow
  );
endinterface

// File: rtl/vote_counter_bank.sv
// N saturating W-bit counters with clear/increment and a registered read port.
module vote_counter_bank
  import vote_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 6,
  localparam int IW = cid_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [IW-1:0] idx,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_q,
  output logic          sat_hit
);

  localparam logic [W-1:0] SAT = W'(sat_max(W));

  logic [W-1:0] cnt_q [N];
  logic [W-1:0] cnt_d [N];
  logic [W-1:0] rd_d;

  // The read port samples the post-update value so a same-cycle increment is visible.
  always_comb begin
    sat_hit = 1'b0;
    rd_d    = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc && idx == IW'(i)) begin
        if (cnt_q[i] == SAT) sat_hit = 1'b1;
        else                 cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rd_idx == IW'(i)) rd_d = cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      rd_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/vote_tally_judge.sv
// Vote accumulator with max scan and judge-round tie break.
//   state    | meaning
//   IDLE     | after reset, waiting for start
//   VOTING   | accepting votes until close
//   SCAN     | one candidate per cycle: max, argmax, tied mask
//   JUDGE    | collecting NUM_JUDGES judge votes for tied candidates
//   JSCAN    | one candidate per cycle over judge tallies of tied candidates
//   DONE     | result held until start
module vote_tally_judge
  import vote_pkg::*;
#(
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = 6,
  parameter int NUM_JUDGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  vote_tally_judge_if.slave bus
);

  localparam int CID_W  = cid_w(NUM_CAND);
  localparam int JCNT_W = jcnt_w(NUM_JUDGES);
  localparam logic [CID_W-1:0] LAST = CID_W'(NUM_CAND - 1);

  vote_state_t         state_q, state_d;
  logic [CID_W-1:0]    idx_q, idx_d, rd_idx;
  logic [CNT_W-1:0]    max_q, max_d, vote_rd;
  logic [CID_W-1:0]    arg_q, arg_d;
  logic [NUM_CAND-1:0] mask_q, mask_d, cur_bit;
  logic [JCNT_W-1:0]   jmax_q, jmax_d, jleft_q, jleft_d, judge_rd;
  logic                jfound_q, jfound_d, jtie_q, jtie_d;
  logic                vote_ready_q, vote_ready_d, judge_ready_q, judge_ready_d;
  logic                result_valid_q, result_valid_d, judged_q, judged_d;
  logic                unresolved_q, unresolved_d, overflow_q, overflow_d;
  logic [CID_W-1:0]    winner_q, winner_d;
  logic                vote_hs, judge_hs, judge_pick, judge_inc;
  logic                vote_sat, judge_sat, cur_tied;

  assign vote_hs   = bus.vote_valid & vote_ready_q & ~bus.start;
  assign judge_hs  = bus.judge_valid & judge_ready_q & ~bus.start;
  assign judge_inc = judge_hs & judge_pick;
  assign cur_tied  = |(mask_q & cur_bit);
  assign rd_idx    = (state_q == S_SCAN || state_q == S_JSCAN) ? idx_q + 1'b1 : '0;

  always_comb begin
    judge_pick = 1'b0;
    cur_bit    = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (bus.judge_cand == CID_W'(i)) judge_pick = mask_q[i];
      cur_bit[i] = (idx_q == CID_W'(i));
    end
  end

  vote_counter_bank #(.N(NUM_CAND), .W(CNT_W)) u_votes (
    .clk(clk), .rst_n(rst_n), .clr(bus.start), .inc(vote_hs), .idx(bus.vote_cand),
    .rd_idx(rd_idx), .rd_q(vote_rd), .sat_hit(vote_sat)
  );

  vote_counter_bank #(.N(NUM_CAND), .W(JCNT_W)) u_judges (
    .clk(clk), .rst_n(rst_n), .clr(bus.start), .inc(judge_inc), .idx(bus.judge_cand),
    .rd_idx(rd_idx), .rd_q(judge_rd), .sat_hit(judge_sat)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    max_d          = max_q;
    arg_d          = arg_q;
    mask_d         = mask_q;
    jmax_d         = jmax_q;
    jleft_d        = jleft_q;
    jfound_d       = jfound_q;
    jtie_d         = jtie_q;
    result_valid_d = result_valid_q;
    winner_d       = winner_q;
    judged_d       = judged_q;
    unresolved_d   = unresolved_q;
    overflow_d     = overflow_q | vote_sat | judge_sat;

    if (bus.start) begin
      state_d        = S_VOTING;
      idx_d          = '0;
      max_d          = '0;
      arg_d          = '0;
      mask_d         = '0;
      jmax_d         = '0;
      jleft_d        = '0;
      jfound_d       = 1'b0;
      jtie_d         = 1'b0;
      result_valid_d = 1'b0;
      winner_d       = '0;
      judged_d       = 1'b0;
      unresolved_d   = 1'b0;
      overflow_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_VOTING: begin
          if (bus.close) begin
            state_d = S_SCAN;
            idx_d   = '0;
          end
        end
        S_SCAN: begin
          if (idx_q == '0 || vote_rd > max_q) begin
            max_d  = vote_rd;
            arg_d  = idx_q;
            mask_d = cur_bit;
          end else if (vote_rd == max_q) begin
            mask_d = mask_q | cur_bit;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_d = '0;
            // A single set bit in the tied mask means a unique maximum.
            if ((mask_d & (mask_d - 1'b1)) == '0) begin
              state_d        = S_DONE;
              result_valid_d = 1'b1;
              winner_d       = arg_d;
              judged_d       = 1'b0;
              unresolved_d   = 1'b0;
            end else begin
              state_d = S_JUDGE;
              jleft_d = JCNT_W'(NUM_JUDGES);
            end
          end
        end
        S_JUDGE: begin
          if (judge_hs) begin
            jleft_d = jleft_q - 1'b1;
            if (jleft_q == JCNT_W'(1)) begin
              state_d  = S_JSCAN;
              idx_d    = '0;
              jmax_d   = '0;
              jfound_d = 1'b0;
              jtie_d   = 1'b0;
            end
          end
        end
        S_JSCAN: begin
          if (cur_tied) begin
            if (!jfound_q || judge_rd > jmax_q) begin
              jmax_d   = judge_rd;
              arg_d    = idx_q;
              jfound_d = 1'b1;
              jtie_d   = 1'b0;
            end else if (judge_rd == jmax_q) begin
              jtie_d = 1'b1;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_d          = '0;
            state_d        = S_DONE;
            result_valid_d = 1'b1;
            winner_d       = arg_d;
            judged_d       = 1'b1;
            unresolved_d   = jtie_d;
          end
        end
        default: ;
      endcase
    end

    vote_ready_d  = (state_d == S_VOTING);
    judge_ready_d = (state_d == S_JUDGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      max_q          <= '0;
      arg_q          <= '0;
      mask_q         <= '0;
      jmax_q         <= '0;
      jleft_q        <= '0;
      jfound_q       <= 1'b0;
      jtie_q         <= 1'b0;
      vote_ready_q   <= 1'b0;
      judge_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      winner_q       <= '0;
      judged_q       <= 1'b0;
      unresolved_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      max_q          <= max_d;
      arg_q          <= arg_d;
      mask_q         <= mask_d;
      jmax_q         <= jmax_d;
      jleft_q        <= jleft_d;
      jfound_q       <= jfound_d;
      jtie_q         <= jtie_d;
      vote_ready_q   <= vote_ready_d;
      judge_ready_q  <= judge_ready_d;
      result_valid_q <= result_valid_d;
      winner_q       <= winner_d;
      judged_q       <= judged_d;
      unresolved_q   <= unresolved_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.vote_ready   = vote_ready_q;
  assign bus.judge_ready  = judge_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.winner       = winner_q;
  assign bus.judged       = judged_q;
  assign bus.unresolved   = unresolved_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_vote_tally_judge.sv
// Scoreboard bench: default instance (4 cand / 4 judges) and a 5 cand / 3 judge instance.
module tb_vote_tally_judge;

  typedef struct packed {
    logic [2:0]  win;
    logic        judged;
    logic        unres;
    logic        ovf;
    logic [31:0] t0;
    logic [31:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic vv = 1'b0, cl = 1'b0, jv = 1'b0;
  logic [2:0] vc = '0, jc = '0;
  logic use_b = 1'b0;
  logic rv_a_prev = 1'b0, rv_b_prev = 1'b0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0, n_done = 0;
  exp_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vote_tally_judge_if #(.CID_W(2)) ia ();
  vote_tally_judge_if #(.CID_W(3)) ib ();

  assign ia.start       = start_a;
  assign ia.vote_valid  = vv;
  assign ia.vote_cand   = vc[1:0];
  assign ia.close       = cl;
  assign ia.judge_valid = jv;
  assign ia.judge_cand  = jc[1:0];
  assign ib.start       = start_b;
  assign ib.vote_valid  = vv;
  assign ib.vote_cand   = vc;
  assign ib.close       = cl;
  assign ib.judge_valid = jv;
  assign ib.judge_cand  = jc;

  vote_tally_judge u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  vote_tally_judge #(.NUM_CAND(5), .CNT_W(6), .NUM_JUDGES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic score(input logic [2:0] w, input logic j, input logic u, input logic o);
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      chk("unexpected_result", 1, 0);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_winner"}, w, e.win);
      chk({t, "_judged"}, j, e.judged);
      chk({t, "_unresolved"}, u, e.unres);
      chk({t, "_overflow"}, o, e.ovf);
      chk({t, "_latency"}, cyc - e.t0, e.lat);
    end
    n_done++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.result_valid && !rv_a_prev) score({1'b0, ia.winner}, ia.judged, ia.unresolved, ia.overflow);
      if (ib.result_valid && !rv_b_prev) score(ib.winner, ib.judged, ib.unresolved, ib.overflow);
    end
    rv_a_prev = ia.result_valid;
    rv_b_prev = ib.result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic jr();
    return use_b ? ib.judge_ready : ia.judge_ready;
  endfunction

  task automatic pulse_start();
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic cast(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      vv = 1'b1;
      vc = c;
      tick();
    end
    vv = 1'b0;
  endtask

  task automatic do_close(output int t0);
    cl = 1'b1;
    t0 = cyc;
    tick();
    cl = 1'b0;
  endtask

  task automatic wait_jready(input string tag, input int t_close, input int lat);
    int k;
    k = 0;
    while (!jr() && k < 40) begin
      tick();
      k++;
    end
    chk(tag, cyc - t_close, lat);
  endtask

  task automatic judge(input logic [2:0] c, output int t_hs);
    int k;
    k = 0;
    t_hs = cyc;
    while (!jr() && k < 40) begin
      tick();
      k++;
    end
    if (!jr()) begin
      chk("judge_ready_timeout", 0, 1);
    end else begin
      jv = 1'b1;
      jc = c;
      t_hs = cyc;
      tick();
      jv = 1'b0;
    end
  endtask

  task automatic expect_res(input string tag, input logic [2:0] w, input logic j, input logic u,
                            input logic o, input int t0, input int lat);
    exp_t e;
    e.win = w; e.judged = j; e.unres = u; e.ovf = o; e.t0 = t0; e.lat = lat;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic wait_result(input string tag);
    int tgt;
    tgt = n_done + 1;
    for (int k = 0; k < 60 && n_done < tgt; k++) tick();
    if (n_done < tgt) begin
      chk({tag, "_timeout"}, 0, 1);
      sb_q.delete();
      tag_q.delete();
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tl;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_vote_ready", ia.vote_ready, 0);
    chk("rst_judge_ready", ia.judge_ready, 0);
    chk("rst_result_valid", ia.result_valid, 0);
    chk("rst_winner", ia.winner, 0);
    chk("rst_flags", {ia.judged, ia.unresolved, ia.overflow}, 0);
    chk("rst_b_outputs", {ib.vote_ready, ib.result_valid, ib.overflow}, 0);

    // unique winner
    pulse_start();
    chk("start_vote_ready", ia.vote_ready, 1);
    cast(0, 17); cast(1, 15); cast(2, 15); cast(3, 53);
    do_close(t0);
    expect_res("unique", 3, 0, 0, 0, t0, 5);
    wait_result("unique");
    repeat (3) tick();
    chk("hold_result_valid", ia.result_valid, 1);
    chk("hold_winner", ia.winner, 3);

    // judge-resolved tie
    pulse_start();
    chk("restart_result_valid", ia.result_valid, 0);
    cast(0, 17); cast(1, 17); cast(2, 5); cast(3, 5);
    do_close(t0);
    wait_jready("tie_jready_lat", t0, 5);
    judge(0, tl); judge(1, tl); judge(1, tl); judge(3, tl);
    expect_res("judge_tie", 1, 1, 0, 0, tl, 5);
    wait_result("judge_tie");

    // unresolved tie
    pulse_start();
    cast(0, 9); cast(1, 9); cast(2, 9); cast(3, 2);
    do_close(t0);
    judge(0, tl); judge(1, tl); judge(2, tl); judge(3, tl);
    expect_res("unresolved", 0, 1, 1, 0, tl, 5);
    wait_result("unresolved");

    // saturation
    pulse_start();
    cast(2, 70); cast(1, 63);
    chk("overflow_sticky", ia.overflow, 1);
    do_close(t0);
    judge(2, tl); judge(2, tl); judge(1, tl); judge(0, tl);
    expect_res("saturate", 2, 1, 0, 1, tl, 5);
    wait_result("saturate");

    // vote in same cycle as close is counted
    pulse_start();
    chk("sat_overflow_cleared", ia.overflow, 0);
    cast(0, 3); cast(1, 3);
    vv = 1'b1; vc = 3'd1; cl = 1'b1; t0 = cyc;
    tick();
    vv = 1'b0; cl = 1'b0;
    expect_res("close_vote", 1, 0, 0, 0, t0, 5);
    wait_result("close_vote");

    // start mid-JUDGE clears both tally banks
    pulse_start();
    cast(0, 2); cast(1, 2);
    do_close(t0);
    judge(0, tl);
    pulse_start();
    chk("abort_vote_ready", ia.vote_ready, 1);
    chk("abort_judge_ready", ia.judge_ready, 0);
    do_close(t0);
    wait_jready("zero_jready_lat", t0, 5);
    judge(3, tl); judge(3, tl); judge(2, tl); judge(0, tl);
    expect_res("abort_judge", 3, 1, 0, 0, tl, 5);
    wait_result("abort_judge");

    // reset during SCAN
    pulse_start();
    cast(0, 64);
    do_close(t0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("scan_rst_outputs",
        {ia.vote_ready, ia.judge_ready, ia.result_valid, ia.judged, ia.unresolved, ia.overflow}, 0);
    chk("scan_rst_winner", ia.winner, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) tick();
    chk("post_rst_idle", {ia.vote_ready, ia.result_valid}, 0);

    // 5 candidates, 3 judges
    use_b = 1'b1;
    pulse_start();
    cast(6, 2); cast(1, 1);
    do_close(t0);
    expect_res("b_ignore_id6", 1, 0, 0, 0, t0, 6);
    wait_result("b_ignore_id6");
    pulse_start();
    do_close(t0);
    wait_jready("b_jready_lat", t0, 6);
    judge(4, tl); judge(4, tl); judge(1, tl);
    expect_res("b_zero_tie", 4, 1, 0, 0, tl, 6);
    wait_result("b_zero_tie");

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vote_tally_judge.md
# vote_tally_judge

Parametrised sequential successor to the four-candidate election circuit. Instead of taking pre-summed vote counts, it accumulates individual votes into saturating per-candidate counters. On close it scans for the maximum. If the top count is tied, it runs a judge round restricted to the tied candidates. It sits between the ballot-entry front end and the result display.

## Interface
- NUM_CAND, 4, number of candidates (2..16); candidate ID width CID_W = clog2(NUM_CAND)
- CNT_W, 6, per-candidate vote counter width
- NUM_JUDGES, 4, judge votes collected in a tie round (1..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: clear all tallies, enter VOTING
- vote_valid  in  1  vote offered
- vote_cand  in  CID_W  candidate voted for
- vote_ready  out  1  high only in VOTING
- close  in  1  pulse: end voting
- judge_valid  in  1  judge vote offered
- judge_cand  in  CID_W  judge's choice
- judge_ready  out  1  high only in JUDGE
- result_valid  out  1  high in DONE
- winner  out  CID_W  winning candidate ID
- judged  out  1  winner decided by judge round
- unresolved  out  1  judge round also tied; lowest-index fallback used
- overflow  out  1  sticky: some counter saturated

## Operation
- States: IDLE, VOTING, SCAN, JUDGE, JSCAN, DONE.
- Reset: state IDLE. All outputs 0. All tallies 0.
- **IDLE**
  - start → VOTING.
  - Tallies are cleared on start, not on entry to IDLE.
- **VOTING**
  - Handshake vote_valid && vote_ready increments tally[vote_cand].
  - vote_cand ≥ NUM_CAND is consumed and ignored.
  - Tallies saturate at 2^CNT_W−1. An increment attempted at saturation sets overflow.
  - close → SCAN. A vote handshaken in the same cycle as close is counted.
- **SCAN**
  - Visits candidates 0..NUM_CAND−1, one per cycle.
  - Tracks max, argmax (first index reaching max) and a tied-mask of candidates equal to max.
  - After the last candidate: exactly one bit set in tied-mask → DONE with winner = argmax, judged = 0. Otherwise → JUDGE.
  - All-zero tallies count as a full tie.
- **JUDGE**
  - Accepts exactly NUM_JUDGES judge handshakes.
  - A judge vote increments jtally[judge_cand] only if that candidate's tied-mask bit is set. Other votes are consumed and ignored.
  - jtally width is clog2(NUM_JUDGES+1).
  - After the last handshake → JSCAN.
- **JSCAN**
  - Scans jtally over tied candidates only, one candidate per cycle.
  - winner = lowest-index maximum. judged = 1.
  - unresolved = 1 if more than one tied candidate shares the judge maximum.
  - → DONE.
- **DONE**
  - result_valid, winner, judged and unresolved are held.
  - start → VOTING with all flags and tallies cleared.
- **start in any state**
  - Aborts the current operation, clears all counts and flags, enters VOTING.
  - start has priority over close and over handshakes in the same cycle.
- close outside VOTING is ignored. vote_valid outside VOTING is ignored (ready is low).

## Timing
- vote_ready and judge_ready are registered state decodes; there is no combinational path from valid to ready.
- Tally updated the cycle after the handshake.
- close in cycle t:
  - SCAN occupies t+1..t+NUM_CAND.
  - With a unique maximum, result_valid rises at t+NUM_CAND+1.
- Tie path:
  - judge_ready rises at t+NUM_CAND+1.
  - Last judge handshake in cycle j → JSCAN occupies j+1..j+NUM_CAND, result_valid rises at j+NUM_CAND+1.
- Reset mid-operation: immediate return to IDLE with all outputs 0, regardless of state.

## Structure
- Package vote_pkg holds:
  - the state enum vote_state_t
  - CID_W and JCNT_W derivation functions
  - the saturation constant helper
- Sub-module vote_counter_bank: NUM_CAND saturating CNT_W-bit counters with clear, increment-enable and index, plus a registered read port used by SCAN.
  - Instantiated twice: votes with width CNT_W, judge tallies with width JCNT_W.
- The top level holds the FSM, the scan index, the max/argmax/tied-mask registers and the handshake logic.

## Test plan
- Unique winner (defaults): cast 17, 15, 15, 53 votes for candidates 0..3, then close → result_valid exactly 5 cycles after close; winner=3, judged=0, unresolved=0.
- Judge-resolved tie: 17, 17, 5, 5, then judges 0, 1, 1, 3 → the vote for 3 is ignored; winner=1, judged=1, unresolved=0.
- Unresolved tie: 9, 9, 9, 2, then judges 0, 1, 2, 3 → winner=0, judged=1, unresolved=1.
- Saturation: 70 votes for candidate 2 and 63 for candidate 1 (CNT_W=6) → overflow=1; both tallies saturate at 63, giving a tie; judges 2, 2, 1, 0 → winner=2.
- Boundary events:
  - Vote handshake in the same cycle as close → counted.
  - start asserted mid-JUDGE → vote_ready=1 next cycle and all tallies 0.
  - rst_n low during SCAN → all outputs 0 immediately.
- Parameter sweep NUM_CAND=5, NUM_JUDGES=3:
  - A vote for ID 6 is consumed and ignored.
  - All-zero tallies → JUDGE; judges 4, 4, 1 → winner=4.
